viterbi_frame_ctrl: RTL and testbench
=====================================

VITERBI_FRAME_CTRL -- requirements
Module: viterbi_frame_ctrl

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- FRAME_LEN, 256, payload bits per frame.
- TAIL_LEN, 2, zero tail bits appended to flush the encoder.
- FLUSH_LEN, 16, idle cycles allowed for decoder drain.
- N, 4, error-trigger width; a burst starts when err_trig[N-1:0] is all ones.
- BURST_LEN, 2, consecutive corrupted symbols per burst.
REQ-002 Ports (name, direction, width, meaning), one per line:
- clk, in, 1, sole clock.
- rst, in, 1, asynchronous active-low reset.
- start, in, 1, begin one frame.
- src_valid, in, 1, payload bit offered.
- src_bit, in, 1, payload bit.
- src_ready, out, 1, controller accepts payload.
- err_en, in, 1, allow error injection.
- err_trig, in, 8, random word, supplied externally.
- enc_enable, out, 1, encoder enable.
- enc_bit, out, 1, encoder data in.
- err_mask, out, 2, XOR mask for the channel symbol.
- busy, out, 1, frame in progress.
- done, out, 1, one-cycle end-of-frame pulse.
- bit_ct, out, 16, payload bits accepted in the current frame.
- err_ct, out, 16, corrupted symbols in the current frame.

Function
REQ-003 FSM states SHALL be IDLE, PAYLOAD, TAIL, FLUSH and DONE.
REQ-004 IDLE SHALL go to PAYLOAD on the cycle after start=1; it SHALL clear bit_ct and err_ct on that same transition.
REQ-005 src_ready SHALL equal 1 only in PAYLOAD, combinationally decoded from state.
REQ-006 A handshake (src_valid&src_ready) SHALL set enc_enable=1 and enc_bit=src_bit on the next cycle and increment bit_ct; with no handshake, enc_enable SHALL be 0 (stall, no bubble filling).
REQ-007 The handshake that makes bit_ct reach FRAME_LEN SHALL move the FSM to TAIL; no further payload SHALL be accepted.
REQ-008 TAIL SHALL drive enc_enable=1, enc_bit=0 for exactly TAIL_LEN cycles, then go to FLUSH.
REQ-009 FLUSH SHALL hold enc_enable=0 for FLUSH_LEN cycles, then go to DONE.
REQ-010 DONE SHALL last one cycle with done=1, then go to IDLE.
REQ-011 busy SHALL be 1 in every state except IDLE.
REQ-012 start SHALL be ignored while busy=1.
REQ-013 Burst start condition: err_en=1, err_trig[N-1:0] all ones, no burst active, and a symbol is issued this cycle (enc_enable=1).
REQ-014 Once started, a burst SHALL corrupt the next BURST_LEN issued symbols, even across TAIL entry; stall cycles SHALL NOT consume burst length.
REQ-015 During a corrupted symbol, err_mask SHALL be err_trig[7:6], forced to 2'b01 if that field is 2'b00; otherwise err_mask=2'b00.
REQ-016 err_ct SHALL increment once per corrupted symbol.
REQ-017 Any active burst SHALL be cancelled on entry to FLUSH.
REQ-018 err_mask SHALL be nonzero only in PAYLOAD or TAIL cycles with enc_enable=1.
REQ-019 bit_ct and err_ct SHALL saturate at 16'hFFFF and hold their values through IDLE until the next start.

Reset
REQ-020 rst=0 SHALL immediately force: state=IDLE; enc_enable=0; enc_bit=0; err_mask=0; busy=0; done=0; bit_ct=0; err_ct=0; burst counter=0.
REQ-021 Reset asserted mid-frame SHALL abandon the frame with no tail and no done pulse.

Structure
REQ-022 The FSM state enum and the default values of FRAME_LEN, TAIL_LEN and FLUSH_LEN SHALL live in a shared package, viterbi_pkg.
REQ-023 Burst tracking SHALL be one sub-module, burst_injector (inputs: issue, trigger hit, cancel; outputs: active, mask strobe).

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- Scenario 1: FRAME_LEN=8, src_valid held 1, err_en=0, one start pulse -> 8 enc_enable cycles carrying src_bit, then 2 cycles of enc_bit=0, then 16 idle cycles, then done=1 for one cycle; err_ct=0, bit_ct=8.
- Scenario 2: src_valid toggled 1,0,1,0 -> enc_enable follows one cycle later with gaps; bit_ct increments only on handshakes.
- Scenario 3: err_en=1, err_trig=8'hCF on one issue cycle, then 8'h00 -> next two issued symbols get err_mask=2'b11; err_ct=2.
- Scenario 4: trigger on the last payload symbol -> burst continues into the first TAIL symbol; a trigger with err_trig[7:6]=00 gives err_mask=2'b01.
- Scenario 5: start pulsed while busy -> ignored, frame completes normally; rst=0 at bit 5 -> all outputs go to 0 immediately, no done pulse, next start runs a clean frame.

Source files
------------

// File: rtl/viterbi_pkg.sv
// viterbi_pkg: FSM encoding, frame-length defaults and a saturating counter helper
// shared by the Viterbi frame controller.
package viterbi_pkg;
    localparam int FRAME_LEN_DEF = 256;
    localparam int TAIL_LEN_DEF  = 2;
    localparam int FLUSH_LEN_DEF = 16;

    typedef enum logic [2:0] {S_IDLE, S_PAYLOAD, S_TAIL, S_FLUSH, S_DONE} state_t;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction
endpackage

// File: rtl/viterbi_frame_ctrl_burst.sv
// burst_injector: counts down the issued symbols left in an error burst; stalls do not
// consume the burst and a cancel clears it.
module burst_injector
    import viterbi_pkg::*;
#(
    parameter int BURST_LEN = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_issue,
    input  logic i_hit,
    input  logic i_cancel,
    output logic o_active,
    output logic o_strobe
);
    localparam int CW = $clog2(BURST_LEN + 1);

    logic [CW-1:0] r_left;

    assign o_active = r_left != '0;
    assign o_strobe = o_active & i_issue;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_left <= '0;
        else if (i_cancel)
            r_left <= '0;
        else if (i_issue && i_hit)
            r_left <= CW'(BURST_LEN);
        else if (o_strobe)
            r_left <= r_left - CW'(1);
    end
endmodule

// File: rtl/viterbi_frame_ctrl.sv
// viterbi_frame_ctrl: sequences payload, zero tail and decoder flush for one encoder frame
// and injects error bursts into the channel symbol stream.
module viterbi_frame_ctrl
    import viterbi_pkg::*;
#(
    parameter int FRAME_LEN = FRAME_LEN_DEF,
    parameter int TAIL_LEN  = TAIL_LEN_DEF,
    parameter int FLUSH_LEN = FLUSH_LEN_DEF,
    parameter int N         = 4,
    parameter int BURST_LEN = 2
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_start,
    input  logic        i_src_valid,
    input  logic        i_src_bit,
    output logic        o_src_ready,
    input  logic        i_err_en,
    input  logic [7:0]  i_err_trig,
    output logic        o_enc_enable,
    output logic        o_enc_bit,
    output logic [1:0]  o_err_mask,
    output logic        o_busy,
    output logic        o_done,
    output logic [15:0] o_bit_ct,
    output logic [15:0] o_err_ct
);
    localparam logic [7:0] HIT_MASK = 8'((1 << N) - 1);

    state_t      r_state, w_next;
    logic [15:0] r_cnt, r_bit_ct, r_err_ct;
    logic [1:0]  r_mask;
    logic        r_enc_en, r_enc_bit;
    logic        w_hs, w_last, w_hit, w_cancel, w_active, w_strobe;

    assign w_hs     = i_src_valid && r_state == S_PAYLOAD;
    assign w_last   = w_hs && r_bit_ct == 16'(FRAME_LEN - 1);
    assign w_hit    = i_err_en && (&(i_err_trig | ~HIT_MASK)) && !w_active;
    assign w_cancel = r_state == S_TAIL && w_next == S_FLUSH;

    // TAIL spends its first cycle presenting the last payload symbol, so it lasts TAIL_LEN+1 cycles
    always_comb begin
        w_next      = r_state;
        o_src_ready = 1'b0;
        o_busy      = 1'b1;
        o_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                o_busy = 1'b0;
                if (i_start) w_next = S_PAYLOAD;
            end
            S_PAYLOAD: begin
                o_src_ready = 1'b1;
                if (w_last) w_next = S_TAIL;
            end
            S_TAIL:  if (r_cnt == 16'(TAIL_LEN)) w_next = S_FLUSH;
            S_FLUSH: if (r_cnt == 16'(FLUSH_LEN - 1)) w_next = S_DONE;
            S_DONE: begin
                o_done = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_enc_en  <= 1'b0;
            r_enc_bit <= 1'b0;
            r_bit_ct  <= '0;
            r_err_ct  <= '0;
            r_mask    <= '0;
        end else begin
            r_state   <= w_next;
            r_cnt     <= (w_next != r_state) ? 16'd0 : r_cnt + 16'd1;
            r_enc_en  <= w_hs || (r_state == S_TAIL && r_cnt < 16'(TAIL_LEN));
            r_enc_bit <= w_hs && i_src_bit;
            // mask field is captured on the trigger symbol and held for the whole burst
            if (!w_active)
                r_mask <= (i_err_trig[7:6] == 2'b00) ? 2'b01 : i_err_trig[7:6];
            if (r_state == S_IDLE && i_start) begin
                r_bit_ct <= '0;
                r_err_ct <= '0;
            end else begin
                if (w_hs) r_bit_ct <= sat_inc(r_bit_ct);
                if (w_strobe) r_err_ct <= sat_inc(r_err_ct);
            end
        end
    end

    burst_injector #(.BURST_LEN(BURST_LEN)) u_burst (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_issue  (r_enc_en),
        .i_hit    (w_hit),
        .i_cancel (w_cancel),
        .o_active (w_active),
        .o_strobe (w_strobe)
    );

    assign o_enc_enable = r_enc_en;
    assign o_enc_bit    = r_enc_bit;
    assign o_err_mask   = w_strobe ? r_mask : 2'b00;
    assign o_bit_ct     = r_bit_ct;
    assign o_err_ct     = r_err_ct;
endmodule

// File: tb/tb_viterbi_frame_ctrl.sv
// tb_viterbi_frame_ctrl: directed frames with a symbol/end-of-frame scoreboard for viterbi_frame_ctrl.
module tb_viterbi_frame_ctrl;
    logic        clk = 1'b0;
    logic        i_rst_n, i_start, i_src_valid, i_src_bit, i_err_en;
    logic [7:0]  i_err_trig;
    logic        o_src_ready, o_enc_enable, o_enc_bit, o_busy, o_done;
    logic [1:0]  o_err_mask;
    logic [15:0] o_bit_ct, o_err_ct;
    logic [38:0] outvec;

    int          checks = 0, errors = 0, done_seen = 0, gap = 0, sidx = 0, trig_at = -1;
    logic [7:0]  trig_val = 8'h00;
    bit          mon_en = 1'b1;
    logic [2:0]  exp_q[$];
    logic [31:0] done_q[$];

    always #5 clk = ~clk;

    assign outvec = {o_enc_enable, o_enc_bit, o_err_mask, o_busy, o_done, o_src_ready, o_bit_ct, o_err_ct};

    viterbi_frame_ctrl #(.FRAME_LEN(8), .TAIL_LEN(2), .FLUSH_LEN(16), .N(4), .BURST_LEN(2)) dut (
        .i_clk(clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_src_valid(i_src_valid),
        .i_src_bit(i_src_bit), .o_src_ready(o_src_ready), .i_err_en(i_err_en),
        .i_err_trig(i_err_trig), .o_enc_enable(o_enc_enable), .o_enc_bit(o_enc_bit),
        .o_err_mask(o_err_mask), .o_busy(o_busy), .o_done(o_done),
        .o_bit_ct(o_bit_ct), .o_err_ct(o_err_ct)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) if (o_done) done_seen++;

    // Trigger word is presented on the cycle a given symbol index is visible
    always @(posedge clk) begin
        #1;
        if (!o_busy) begin
            sidx = 0;
            i_err_trig = 8'h00;
        end else begin
            i_err_trig = (o_enc_enable && sidx == trig_at) ? trig_val : 8'h00;
            if (o_enc_enable) sidx++;
        end
    end

    always @(negedge clk) begin
        logic [31:0] e;
        if (mon_en && i_rst_n) begin
            if (o_enc_enable) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sym_unexpected actual=%0b%0b required=none", o_enc_bit, o_err_mask);
                end else chk("sym", {o_enc_bit, o_err_mask}, exp_q.pop_front());
                gap = 0;
            end else begin
                chk("mask_idle", o_err_mask, 0);
                if (o_done) begin
                    if (done_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL done_unexpected actual=1 required=0");
                    end else begin
                        e = done_q.pop_front();
                        chk("done_bit_ct", o_bit_ct, e[31:16]);
                        chk("done_err_ct", o_err_ct, e[15:0]);
                        chk("done_gap", gap, 16);
                        chk("sym_left", exp_q.size(), 0);
                    end
                end else gap++;
            end
        end
    end

    task automatic run_frame(input logic [7:0] bits, input bit tog, input int tat, input logic [7:0] tv,
                             input logic [19:0] masks, input logic [15:0] exp_err, input bit glitch);
        int idx, cyc, w, d0;
        logic hs;
        for (int i = 0; i < 10; i++)
            exp_q.push_back({(i < 8) ? bits[i[2:0]] : 1'b0, masks[2*i +: 2]});
        done_q.push_back({16'd8, exp_err});
        trig_at = tat;
        trig_val = tv;
        @(posedge clk); #1 i_start = 1'b1;
        @(posedge clk); #1 i_start = 1'b0;
        idx = 0;
        cyc = 0;
        while (idx < 8 && cyc < 100) begin
            i_src_valid = tog ? (cyc % 2 == 0) : 1'b1;
            i_src_bit = bits[idx[2:0]];
            i_start = glitch && cyc == 3;
            @(negedge clk) hs = i_src_valid && o_src_ready;
            @(posedge clk); #1;
            if (hs) idx++;
            cyc++;
        end
        i_src_valid = 1'b0;
        i_start = 1'b0;
        d0 = done_seen;
        w = 0;
        while (done_seen == d0 && w < 100) begin
            @(posedge clk); #1;
            w++;
        end
        chk("done_seen", done_seen, d0 + 1);
        repeat (3) @(posedge clk);
        #1;
        chk("hold_bit_ct", o_bit_ct, 8);
        chk("hold_err_ct", o_err_ct, exp_err);
        chk("idle_busy", o_busy, 0);
    endtask

    initial begin
        int idx, w, d0;
        logic hs;
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int idx, w, d0;
        logic hs;
        i_rst_n = 1'b1; i_start = 1'b0; i_src_valid = 1'b0; i_src_bit = 1'b0; i_err_en = 1'b0;
        #3 i_rst_n = 1'b0;
        #1 chk("reset_outputs", outvec, 0);
        repeat (2) @(negedge clk);
        i_rst_n = 1'b1;
        run_frame(8'hB2, 1'b0, -1, 8'h00, 20'h00000, 16'd0, 1'b0);
        run_frame(8'h5A, 1'b1, -1, 8'h00, 20'h00000, 16'd0, 1'b0);
        i_err_en = 1'b1;
        run_frame(8'hC3, 1'b1, 2, 8'hCF, 20'h003C0, 16'd2, 1'b0);
        run_frame(8'hFF, 1'b0, 7, 8'h0F, 20'h50000, 16'd2, 1'b0);
        run_frame(8'h00, 1'b0, 8, 8'h8F, 20'h80000, 16'd1, 1'b0);
        run_frame(8'h96, 1'b0, -1, 8'h00, 20'h00000, 16'd0, 1'b1);
        i_err_en = 1'b0;
        mon_en = 1'b0;
        @(posedge clk); #1 i_start = 1'b1;
        @(posedge clk); #1 i_start = 1'b0;
        idx = 0;
        w = 0;
        i_src_valid = 1'b1;
        while (idx < 5 && w < 50) begin
            i_src_bit = w[0];
            @(negedge clk) hs = i_src_valid && o_src_ready;
            @(posedge clk); #1;
            if (hs) idx++;
            w++;
        end
        chk("abort_bit_ct", o_bit_ct, 5);
        d0 = done_seen;
        #2 i_rst_n = 1'b0;
        #1 chk("abort_outputs", outvec, 0);
        i_src_valid = 1'b0;
        @(negedge clk) i_rst_n = 1'b1;
        repeat (30) @(posedge clk);
        #1 chk("abort_no_done", done_seen, d0);
        chk("abort_idle", o_busy, 0);
        mon_en = 1'b1;
        run_frame(8'hB2, 1'b0, -1, 8'h00, 20'h00000, 16'd0, 1'b0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
